lfsr_gen: RTL and testbench

Parametrised pseudo-random bit generator; successor to the single-bit LFSR. Supports runtime-selectable Fibonacci or Galois feedback and emits OUT_W sequential LFSR bits per accepted word. Seed, tap mask and mode are loaded through a valid/ready config port; words are delivered through a valid/ready output port. Sits between the test-pattern/scrambler control logic and bit-serial consumers needing backpressure.

---
 rtl/lfsr_gen.sv | 127 ++++++++++++
 tb/tb_lfsr_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci/Galois LFSR word generator with valid/ready config and output ports
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN (zero-seed recovery and lockup pulse).
module lfsr_gen #(
  parameter int NBITS = 8,
  parameter int OUT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_val,
  output logic             cfg_rdy,
  input  logic [NBITS-1:0] cfg_tap,
  input  logic [NBITS-1:0] cfg_seed,
  input  logic             cfg_galois,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [OUT_W-1:0] out_data,
  output logic [15:0]      word_cnt
`ifdef LFSR_LOCKUP_RECOVER_EN
  ,
  output logic             lockup
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Tap bit 0 never participates in feedback.
  localparam logic [NBITS-1:0] TAP_MASK = {{(NBITS-1){1'b1}}, 1'b0};
  localparam logic [NBITS-1:0] ONE      = {{(NBITS-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [NBITS-1:0] q;
  logic [NBITS-1:0] tap;
  logic             galois;
  logic [NBITS-1:0] q_adv;
  logic [NBITS-1:0] seed_eff;
  logic             word_take;

  function automatic logic [NBITS-1:0] lfsr_step(
    input logic [NBITS-1:0] s,
    input logic [NBITS-1:0] t,
    input logic             g
  );
    logic [NBITS-1:0] nxt;
    logic             b;
    b   = s[0];
    nxt = '0;
    if (g) begin
      nxt[NBITS-1] = b;
      for (int i = 0; i < NBITS - 1; i++) begin
        nxt[i] = s[i+1] ^ (t[i+1] & b);
      end
    end else begin
      nxt = {b ^ (^(s & t & TAP_MASK)), s[NBITS-1:1]};
    end
    return nxt;
  endfunction

  // Unroll OUT_W steps: each step contributes its q[0] and feeds the next.
  always_comb begin
    logic [NBITS-1:0] cur;
    out_data = '0;
    cur      = q;
    for (int j = 0; j < OUT_W; j++) begin
      out_data[j] = cur[0];
      cur         = lfsr_step(cur, tap, galois);
    end
    q_adv = cur;
  end

  always_comb begin
    state_nxt = state;
    if (cfg_val) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign cfg_rdy   = 1'b1;
  assign out_val   = (state == RUN);
  assign word_take = out_val && out_rdy;

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign seed_eff = (cfg_seed == '0) ? ONE : cfg_seed;
`else
  assign seed_eff = cfg_seed;
`endif

  // A config load takes priority over a concurrent word step.
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      tap      <= '0;
      galois   <= 1'b0;
      word_cnt <= 16'd0;
    end else if (cfg_val) begin
      q        <= seed_eff;
      tap      <= cfg_tap;
      galois   <= cfg_galois;
      word_cnt <= 16'd0;
    end else if (word_take) begin
      q        <= q_adv;
      word_cnt <= word_cnt + 16'd1;
    end
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lockup <= 1'b0;
    end else begin
      lockup <= cfg_val && (cfg_seed == '0);
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed-vector bench for lfsr_gen (NBITS=4, OUT_W=1 and OUT_W=4)
module tb_lfsr_gen;

  logic        clk;
  logic        rst;
  logic        cfg_val;
  logic        cfg_rdy1, cfg_rdy4;
  logic [3:0]  cfg_tap;
  logic [3:0]  cfg_seed;
  logic        cfg_galois;
  logic        out_val1, out_val4;
  logic        out_rdy;
  logic [0:0]  out_data1;
  logic [3:0]  out_data4;
  logic [15:0] word_cnt1, word_cnt4;
`ifdef LFSR_LOCKUP_RECOVER_EN
  logic        lockup1, lockup4;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [14:0] fib_seq;

  lfsr_gen #(.NBITS(4), .OUT_W(1)) dut1 (
    .clk(clk), .rst(rst), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy1),
    .cfg_tap(cfg_tap), .cfg_seed(cfg_seed), .cfg_galois(cfg_galois),
    .out_val(out_val1), .out_rdy(out_rdy), .out_data(out_data1),
    .word_cnt(word_cnt1)
`ifdef LFSR_LOCKUP_RECOVER_EN
    , .lockup(lockup1)
`endif
  );

  lfsr_gen #(.NBITS(4), .OUT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy4),
    .cfg_tap(cfg_tap), .cfg_seed(cfg_seed), .cfg_galois(cfg_galois),
    .out_val(out_val4), .out_rdy(out_rdy), .out_data(out_data4),
    .word_cnt(word_cnt4)
`ifdef LFSR_LOCKUP_RECOVER_EN
    , .lockup(lockup4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] seed, input logic [3:0] tap, input logic gal);
    cfg_val    = 1'b1;
    cfg_seed   = seed;
    cfg_tap    = tap;
    cfg_galois = gal;
    tick();
    cfg_val    = 1'b0;
  endtask

  initial begin
    // bit k = k-th emitted bit of Fibonacci tap=0010 seed=0001
    fib_seq    = 15'b111_0101_1001_0001;
    rst        = 1'b1;
    cfg_val    = 1'b0;
    cfg_tap    = 4'b0;
    cfg_seed   = 4'b0;
    cfg_galois = 1'b0;
    out_rdy    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_val", out_val1, 0);
    check("rst_out_data", out_data1, 0);
    check("rst_out_data4", out_data4, 0);
    check("rst_word_cnt", word_cnt1, 0);
    check("rst_cfg_rdy", cfg_rdy1, 1);
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("rst_lockup", lockup1, 0);
`endif
    tick();
    check("idle_out_val", out_val1, 0);

    // Fibonacci full period
    load(4'b0001, 4'b0010, 1'b0);
    check("cfg_out_val", out_val1, 1);
    check("fib4_w0", out_data4, 4'b0001);
    for (int k = 0; k < 15; k++) begin
      check($sformatf("fib_bit%0d", k), out_data1, fib_seq[k]);
      if (k == 1) check("fib4_w1", out_data4, 4'b1001);
      if (k == 2) check("fib4_w2", out_data4, 4'b0101);
      if (k == 3) check("fib4_w3", out_data4, 4'b1111);
      tick();
    end
    check("fib_word_cnt15", word_cnt1, 15);
    check("fib_repeat", out_data1, fib_seq[0]);

    // Backpressure mid-stream
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_pre%0d", k), out_data1, fib_seq[k]);
      tick();
    end
    out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold_data%0d", k), out_data1, fib_seq[3]);
      check($sformatf("bp_hold_cnt%0d", k), word_cnt1, 18);
    end
    out_rdy = 1'b1;
    for (int k = 3; k < 6; k++) begin
      check($sformatf("bp_resume%0d", k), out_data1, fib_seq[k]);
      tick();
    end
    check("bp_word_cnt", word_cnt1, 21);

    // Config concurrent with a handshake
    load(4'b1000, 4'b0010, 1'b0);
    check("reload_data", out_data1, 0);
    check("reload_data4", out_data4, 4'b1000);
    check("reload_cnt", word_cnt1, 0);
    tick();
    check("reload_cnt1", word_cnt1, 1);

    // Galois
    load(4'b0001, 4'b0010, 1'b1);
    check("gal_b0", out_data1, 1);
    check("gal4_w0", out_data4, 4'b1111);
    tick();
    check("gal_b1", out_data1, 1);
    check("gal4_w1", out_data4, 4'b1010);
    tick();
    check("gal_b2", out_data1, 1);
    tick();
    check("gal_b3", out_data1, 1);
    tick();
    check("gal_b4", out_data1, 0);

    // Reset mid-stream, overriding a concurrent config
    rst     = 1'b1;
    cfg_val = 1'b1;
    tick();
    rst     = 1'b0;
    cfg_val = 1'b0;
    check("midrst_out_val", out_val1, 0);
    check("midrst_cnt", word_cnt1, 0);
    check("midrst_data", out_data1, 0);

    // Zero seed
    load(4'b0000, 4'b0010, 1'b0);
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("zero_lockup", lockup1, 1);
    check("zero_q", out_data4, 4'b0001);
    for (int k = 0; k < 15; k++) begin
      check($sformatf("zero_bit%0d", k), out_data1, fib_seq[k]);
      tick();
      check($sformatf("zero_lockup_low%0d", k), lockup1, 0);
    end
`else
    for (int k = 0; k < 4; k++) begin
      check($sformatf("zero_val%0d", k), out_val1, 1);
      check($sformatf("zero_data%0d", k), out_data4, 0);
      tick();
    end
    check("zero_cnt", word_cnt1, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
